// File: rtl/ghost_mode_timer.sv
// Ghost mode sequencer: scatter/chase schedule driven by the 1 Hz tick,
// with a frightened override when a power pellet is eaten.
module ghost_mode_timer #(
    parameter logic [7:0] SCATTER_S = 8'd7,
    parameter logic [7:0] CHASE_S   = 8'd20,
    parameter logic [7:0] FRIGHT_S  = 8'd6,
    parameter logic [7:0] FLASH_S   = 8'd2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       sec,
    input  logic       start,
    input  logic       pause,
    input  logic       pellet_eaten,
    output logic [1:0] mode,
    output logic       fright_flash,
    output logic       mode_change,
    output logic [2:0] phase_idx,
    output logic [7:0] secs_left
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FRIGHT
    } state_t;

    localparam logic [1:0] M_IDLE    = 2'd0;
    localparam logic [1:0] M_SCATTER = 2'd1;
    localparam logic [1:0] M_CHASE   = 2'd2;
    localparam logic [1:0] M_FRIGHT  = 2'd3;

    state_t     r_state;
    logic [2:0] r_phase;
    logic [7:0] r_base;
    logic [7:0] r_fright;
    logic [1:0] r_mode;
    logic       r_flash;
    logic       r_mode_change;
    logic [7:0] r_secs_left;

    wire [2:0] w_next_phase = r_phase + 3'd1;

    // Phase 7 is the endless chase; its timer is held at 0.
    function automatic logic [7:0] phase_len(input logic [2:0] p);
        if (p == 3'd7)
            return 8'd0;
        else if (p[0])
            return CHASE_S;
        else
            return SCATTER_S;
    endfunction

    function automatic logic [1:0] phase_mode(input logic [2:0] p);
        return p[0] ? M_CHASE : M_SCATTER;
    endfunction

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state       <= S_IDLE;
            r_phase       <= 3'd0;
            r_base        <= 8'd0;
            r_fright      <= 8'd0;
            r_mode        <= M_IDLE;
            r_flash       <= 1'b0;
            r_mode_change <= 1'b0;
            r_secs_left   <= 8'd0;
        end else begin
            r_mode_change <= 1'b0;
            if (!start) begin
                r_state     <= S_IDLE;
                r_phase     <= 3'd0;
                r_base      <= 8'd0;
                r_fright    <= 8'd0;
                r_mode      <= M_IDLE;
                r_flash     <= 1'b0;
                r_secs_left <= 8'd0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_state       <= S_RUN;
                        r_phase       <= 3'd0;
                        r_base        <= SCATTER_S;
                        r_fright      <= 8'd0;
                        r_mode        <= M_SCATTER;
                        r_flash       <= 1'b0;
                        r_secs_left   <= SCATTER_S;
                        r_mode_change <= 1'b1;
                    end
                    S_RUN: begin
                        if (pellet_eaten) begin
                            r_state       <= S_FRIGHT;
                            r_fright      <= FRIGHT_S;
                            r_mode        <= M_FRIGHT;
                            r_flash       <= (FRIGHT_S <= FLASH_S);
                            r_secs_left   <= FRIGHT_S;
                            r_mode_change <= 1'b1;
                        end else if (sec && !pause && r_phase != 3'd7) begin
                            if (r_base > 8'd1) begin
                                r_base      <= r_base - 8'd1;
                                r_secs_left <= r_base - 8'd1;
                            end else begin
                                r_phase       <= w_next_phase;
                                r_base        <= phase_len(w_next_phase);
                                r_secs_left   <= phase_len(w_next_phase);
                                r_mode        <= phase_mode(w_next_phase);
                                r_mode_change <= 1'b1;
                            end
                        end
                    end
                    S_FRIGHT: begin
                        if (pellet_eaten) begin
                            r_fright      <= FRIGHT_S;
                            r_flash       <= (FRIGHT_S <= FLASH_S);
                            r_secs_left   <= FRIGHT_S;
                            r_mode_change <= 1'b1;
                        end else if (sec && !pause) begin
                            if (r_fright > 8'd1) begin
                                r_fright    <= r_fright - 8'd1;
                                r_secs_left <= r_fright - 8'd1;
                                r_flash     <= (r_fright - 8'd1 <= FLASH_S);
                            end else begin
                                r_state       <= S_RUN;
                                r_fright      <= 8'd0;
                                r_flash       <= 1'b0;
                                r_mode        <= phase_mode(r_phase);
                                r_secs_left   <= r_base;
                                r_mode_change <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign mode         = r_mode;
    assign fright_flash = r_flash;
    assign mode_change  = r_mode_change;
    assign phase_idx    = r_phase;
    assign secs_left    = r_secs_left;

endmodule

// File: tb/tb_ghost_mode_timer.sv
// Directed bench for ghost_mode_timer: schedule, fright override,
// pause, reset and start priority.
module tb_ghost_mode_timer;

    logic       Clk;
    logic       Reset;
    logic       sec;
    logic       start;
    logic       pause;
    logic       pellet_eaten;
    logic [1:0] mode;
    logic       fright_flash;
    logic       mode_change;
    logic [2:0] phase_idx;
    logic [7:0] secs_left;

    int n_cmp;
    int n_err;
    int mc_cnt;

    ghost_mode_timer dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .sec          (sec),
        .start        (start),
        .pause        (pause),
        .pellet_eaten (pellet_eaten),
        .mode         (mode),
        .fright_flash (fright_flash),
        .mode_change  (mode_change),
        .phase_idx    (phase_idx),
        .secs_left    (secs_left)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input bit s, input bit pe);
        sec          = s;
        pellet_eaten = pe;
        @(posedge Clk);
        #1;
        sec          = 1'b0;
        pellet_eaten = 1'b0;
        if (mode_change)
            mc_cnt++;
    endtask

    task automatic secs(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b1, 1'b0);
    endtask

    task automatic st(input string tag, input int m, input int p,
                      input int s);
        chk({tag, ".mode"}, int'(mode), m);
        chk({tag, ".phase"}, int'(phase_idx), p);
        chk({tag, ".secs"}, int'(secs_left), s);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        mc_cnt       = 0;
        Reset        = 1'b0;
        start        = 1'b0;
        pause        = 1'b0;
        sec          = 1'b0;
        pellet_eaten = 1'b0;
        #25;
        st("rst", 0, 0, 0);
        chk("rst.mc", int'(mode_change), 0);
        chk("rst.flash", int'(fright_flash), 0);

        Reset = 1'b1;
        start = 1'b1;
        cyc(0, 0);
        st("start", 1, 0, 7);
        chk("start.mc", int'(mode_change), 1);
        cyc(0, 0);
        chk("start.mc_low", int'(mode_change), 0);
        secs(6);
        st("sc_last", 1, 0, 1);
        secs(1);
        st("chase1", 2, 1, 20);
        chk("chase1.mc", int'(mode_change), 1);
        secs(27);
        st("phase3", 2, 3, 20);

        #3 Reset = 1'b0;
        #1;
        st("async_rst", 0, 0, 0);
        chk("async_rst.mc", int'(mode_change), 0);
        #3 Reset = 1'b1;
        cyc(0, 0);
        st("restart", 1, 0, 7);
        chk("restart.mc", int'(mode_change), 1);

        mc_cnt = 0;
        secs(7 + 20 + 7 + 20 + 7 + 20 + 7);
        st("ph7", 2, 7, 0);
        chk("ph7.mc_cnt", mc_cnt, 7);
        mc_cnt = 0;
        secs(100);
        st("ph7_hold", 2, 7, 0);
        chk("ph7_hold.mc_cnt", mc_cnt, 0);
        cyc(0, 1);
        st("ph7_fr", 3, 7, 6);
        secs(6);
        st("ph7_back", 2, 7, 0);
        chk("ph7_back.mc", int'(mode_change), 1);

        start = 1'b0;
        cyc(0, 0);
        st("stop", 0, 0, 0);
        chk("stop.mc", int'(mode_change), 0);
        cyc(0, 1);
        st("idle_pellet", 0, 0, 0);
        start = 1'b1;
        cyc(0, 0);
        secs(7 + 8);
        st("ph1_12", 2, 1, 12);
        cyc(0, 1);
        st("fr", 3, 1, 6);
        chk("fr.mc", int'(mode_change), 1);
        chk("fr.flash", int'(fright_flash), 0);
        secs(3);
        chk("fr3.secs", int'(secs_left), 3);
        chk("fr3.flash", int'(fright_flash), 0);
        secs(1);
        chk("fr2.secs", int'(secs_left), 2);
        chk("fr2.flash", int'(fright_flash), 1);
        cyc(0, 1);
        st("refr", 3, 1, 6);
        chk("refr.flash", int'(fright_flash), 0);
        chk("refr.mc", int'(mode_change), 1);
        secs(5);
        st("fr1", 3, 1, 1);
        chk("fr1.flash", int'(fright_flash), 1);
        secs(1);
        st("fr_end", 2, 1, 12);
        chk("fr_end.mc", int'(mode_change), 1);
        chk("fr_end.flash", int'(fright_flash), 0);

        secs(7);
        st("run5", 2, 1, 5);
        cyc(1, 1);
        st("both", 3, 1, 6);
        secs(6);
        st("both_end", 2, 1, 5);

        pause = 1'b1;
        secs(10);
        st("pause", 2, 1, 5);
        cyc(0, 1);
        st("pause_pel", 3, 1, 6);
        secs(3);
        st("pause_fr", 3, 1, 6);
        start = 1'b0;
        cyc(0, 0);
        st("final_stop", 0, 0, 0);
        chk("final_stop.flash", int'(fright_flash), 0);
        chk("final_stop.mc", int'(mode_change), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ghost_mode_timer.md
Name: ghost_mode_timer

Overview:
- Consumes the 1 Hz `sec` tick from the second-counter path and sequences ghost behaviour modes through the Pac-Man scatter/chase schedule.
- A frightened override is triggered by power-pellet events.
- Outputs feed ghost AI target selection and sprite colouring.
- Holds its own per-phase countdown; does not write the global game counter.

Parameters:
SCATTER_S, 7, scatter phase length in seconds
CHASE_S, 20, chase phase length in seconds (phases 1,3,5)
FRIGHT_S, 6, frightened duration in seconds
FLASH_S, 2, final seconds of fright during which fright_flash asserts (must be < FRIGHT_S)

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  asynchronous, active-low reset
sec  in  1  one-cycle pulse per second
start  in  1  level: 1 = level running, 0 = return to IDLE
pause  in  1  level: 1 freezes all timers (death animation, level clear)
pellet_eaten  in  1  one-cycle pulse when a power pellet is consumed
mode  out  2  0 = IDLE, 1 = SCATTER, 2 = CHASE, 3 = FRIGHT
fright_flash  out  1  1 when in FRIGHT and fright_left <= FLASH_S
mode_change  out  1  one-cycle pulse on every mode transition into SCATTER/CHASE/FRIGHT (ghosts reverse direction)
phase_idx  out  3  current schedule phase 0..7
secs_left  out  8  seconds remaining in the active timer (fright timer while in FRIGHT)

Behaviour:
- Reset (Reset=0, async) values: mode=IDLE, fright_flash=0, mode_change=0, phase_idx=0, secs_left=0, internal base and fright timers = 0.
- All outputs are registered. Response to any input appears on the next rising Clk edge.
- Schedule:
  - Even phases 0,2,4,6 are SCATTER, length SCATTER_S.
  - Odd phases 1,3,5 are CHASE, length CHASE_S.
  - Phase 7 is CHASE with infinite length: secs_left=0, no further advance.
- States: IDLE, RUN, FRIGHT.
- IDLE:
  - sec and pellet_eaten are ignored.
  - On start=1: go to RUN, phase_idx=0, base timer=SCATTER_S, mode=SCATTER, pulse mode_change.
- RUN:
  - On sec with pause=0 and base timer > 1: decrement the base timer.
  - On sec with base timer == 1 and phase_idx < 7: phase_idx+1, load the next phase length, update mode, pulse mode_change.
  - Phase 7: sec is ignored.
  - secs_left mirrors the base timer.
- RUN -> FRIGHT on pellet_eaten (pause ignored):
  - fright timer = FRIGHT_S, mode=FRIGHT, pulse mode_change.
  - Base timer and phase_idx are frozen, not reset.
- FRIGHT:
  - sec with pause=0 decrements the fright timer; secs_left shows the fright timer.
  - On sec with fright timer == 1: return to RUN, restore mode from phase_idx parity/phase 7, secs_left = frozen base timer, pulse mode_change.
  - pellet_eaten in FRIGHT: reload fright timer to FRIGHT_S, pulse mode_change, fright_flash drops to 0.
- pause=1: no timer decrements. Transitions driven by pellet_eaten and start still occur.
- sec and pellet_eaten in the same cycle: pellet wins. That sec is discarded; no decrement of either timer.
- start=0 in any state: next cycle IDLE with all outputs at reset values, except mode_change=0.
- start=0 has priority over all other inputs.
- mode_change is never high for two consecutive cycles, except for back-to-back pellet pulses.
- Timers are 8-bit unsigned; parameters must be 1..255. No wrap: a timer never decrements below 1 while active.

Test Plan:
1. Reset low mid-RUN (phase 3) -> all outputs 0 immediately; after release with start=1, next edge gives mode=1, phase_idx=0, secs_left=7, mode_change pulse.
2. start=1, 7 sec pulses -> mode 1->2 on the 7th, phase_idx=1, secs_left=20. Full schedule via 7+20+7+20+5(scatter?no: 7)+20+7 pulses reaches phase 7; 100 further pulses leave phase_idx=7, secs_left=0, no mode_change.
3. At phase 1 with secs_left=12, pellet_eaten -> mode=3, secs_left=6. After 4 sec pulses fright_flash=1 (secs_left=2). 2 more sec pulses -> mode=2, secs_left=12, mode_change pulse.
4. In FRIGHT with secs_left=2 (flashing), second pellet_eaten -> secs_left=6, fright_flash=0, mode_change pulse.
5. sec and pellet_eaten in the same cycle during RUN with secs_left=5 -> mode=3, secs_left=6; base timer still 5 after fright ends.
6. pause=1 with 10 sec pulses -> secs_left unchanged. start=0 -> next edge mode=0, phase_idx=0, secs_left=0.
